// File: rtl/div_shift.sv
// Sequential restoring shift-subtract unsigned divider, one quotient bit per clock.
// Optional divide-by-zero detection via DIV_ZERO_DET_EN (adds the div_zero port and an early-out path).
module div_shift #(
  parameter int unsigned WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
`ifdef DIV_ZERO_DET_EN
  ,
  output logic             div_zero
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic             w_last;
  logic             w_zero;

  // Trial value keeps the carry bit; the difference fits in WIDTH bits whenever it is used.
  always_comb begin
    w_trial = {r_rem, r_dvd[WIDTH-1]};
    w_ge    = (w_trial >= {1'b0, r_dvsr});
    w_diff  = w_trial[WIDTH-1:0] - r_dvsr;
    w_last  = (r_cnt == CW'(WIDTH));
`ifdef DIV_ZERO_DET_EN
    w_zero  = (bin == '0);
`else
    w_zero  = 1'b0;
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_zero ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dvd     <= '0;
      r_dvsr    <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_DET_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd  <= ain;
            r_dvsr <= bin;
            r_rem  <= '0;
            r_cnt  <= '0;
`ifdef DIV_ZERO_DET_EN
            div_zero <= w_zero;
            if (w_zero) begin
              quotient  <= '1;
              remainder <= ain;
            end
`endif
          end
        end
        S_CALC: begin
          // Dividend register doubles as the quotient shift register.
          if (!w_last) begin
            r_rem <= w_ge ? w_diff : w_trial[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
          end else begin
            quotient  <= r_dvd;
            remainder <= r_rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
